// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative binary-to-BCD converter using shift-add-3 (double dabble), one
// input bit per clock, with per-digit 7-segment encoding of the result.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   conversion request, honoured in IDLE and DONE only
//   bin_in   in   WIDTH-bit unsigned value, captured when start is accepted
//   busy     out  high while iterating
//   done     out  one-cycle pulse marking a new result on bcd_out/seg_out
//   bcd_out  out  packed BCD, digit k at [4k+3:4k], digit 0 = units
//   seg_out  out  7-segment digits, digit k at [7k+6:7k], order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DIGITS         = 3,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SEG_W = 7 * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_ok();
        longint unsigned p;
        longint unsigned maxv;
        p    = 64'd1;
        maxv = (64'd1 << WIDTH) - 64'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            // Stop growing once large enough so the product cannot overflow.
            if (p <= maxv) p = p * 64'd10;
        end
        return p > maxv;
    endfunction

    localparam bit DIGITS_OK = digits_ok();

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("bin_to_bcd_seq: WIDTH=%0d outside 1..32", WIDTH);
        end
        if (!DIGITS_OK) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS=%0d too few for WIDTH=%0d", DIGITS, WIDTH);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_shreg;
    logic [BCD_W-1:0]    r_scratch;
    logic [BCD_W-1:0]    r_bcd;

    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W-1:0]    w_next_scratch;
    logic                w_accept;
    logic                w_last;
    logic [SEG_W-1:0]    w_seg;

    // Add-3 correction on every digit >= 5 before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
        end
    end

    // Shreg MSB feeds the scratch LSB.
    assign w_next_scratch = {w_adj[BCD_W-2:0], r_shreg[WIDTH-1]};

    // IDLE and DONE both accept a new request.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_shreg   <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shreg   <= r_shreg << 1;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd   <= w_next_scratch;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Active-high {g,f,e,d,c,b,a} pattern; codes 10..15 are dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b0111111;
            4'd1:    seg_encode = 7'b0000110;
            4'd2:    seg_encode = 7'b1011011;
            4'd3:    seg_encode = 7'b1001111;
            4'd4:    seg_encode = 7'b1100110;
            4'd5:    seg_encode = 7'b1101101;
            4'd6:    seg_encode = 7'b1111101;
            4'd7:    seg_encode = 7'b0000111;
            4'd8:    seg_encode = 7'b1111111;
            4'd9:    seg_encode = 7'b1101111;
            default: seg_encode = 7'b0000000;
        endcase
    endfunction

    // Segment encoding, walking from the top digit to track leading zeros.
    always_comb begin : seg_map
        logic       zero_above;
        logic [6:0] raw;
        w_seg      = '0;
        zero_above = 1'b1;
        raw        = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_above = zero_above && (r_bcd[4*k +: 4] == 4'd0);
            if (BLANK_LEADING && (k != 0) && zero_above) raw = 7'b0000000;
            else                                         raw = seg_encode(r_bcd[4*k +: 4]);
            w_seg[7*k +: 7] = SEG_ACTIVE_LOW ? ~raw : raw;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign seg_out = w_seg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed bench for bin_to_bcd_seq over four parameter sets:
//   u8  : WIDTH=8,  DIGITS=3, active-low, no blanking
//   u8b : WIDTH=8,  DIGITS=3, active-low, leading-zero blanking
//   u16 : WIDTH=16, DIGITS=5, active-high, leading-zero blanking
//   u1  : WIDTH=1,  DIGITS=1, active-low, no blanking
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst_n;

    logic        s8,  busy8,  done8;
    logic [7:0]  b8;
    logic [11:0] bcd8;
    logic [20:0] seg8;

    logic        sb,  busyb,  doneb;
    logic [7:0]  bb;
    logic [11:0] bcdb;
    logic [20:0] segb;

    logic        s16, busy16, done16;
    logic [15:0] b16;
    logic [19:0] bcd16;
    logic [34:0] seg16;

    logic        s1,  busy1,  done1;
    logic [0:0]  b1;
    logic [3:0]  bcd1;
    logic [6:0]  seg1;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .bin_in(b8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .seg_out(seg8));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u8b (
        .clk(clk), .rst_n(rst_n), .start(sb), .bin_in(bb),
        .busy(busyb), .done(doneb), .bcd_out(bcdb), .seg_out(segb));

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) u16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .bin_in(b16),
        .busy(busy16), .done(done16), .bcd_out(bcd16), .seg_out(seg16));

    bin_to_bcd_seq #(.WIDTH(1), .DIGITS(1), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .bin_in(b1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .seg_out(seg1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done8;
            1:       return doneb;
            2:       return done16;
            default: return done1;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy8;
            1:       return busyb;
            2:       return busy16;
            default: return busy1;
        endcase
    endfunction

    function automatic logic [63:0] get_bcd(input int sel);
        case (sel)
            0:       return 64'(bcd8);
            1:       return 64'(bcdb);
            2:       return 64'(bcd16);
            default: return 64'(bcd1);
        endcase
    endfunction

    function automatic int width_of(input int sel);
        case (sel)
            0, 1:    return 8;
            2:       return 16;
            default: return 1;
        endcase
    endfunction

    // Start one conversion on instance sel, wait (bounded) for done and
    // check latency, busy duration, and that the old result held meanwhile.
    task automatic run(input int sel, input logic [15:0] val, input string tag);
        int          n;
        int          nb;
        bit          held;
        logic [63:0] prev;
        prev = get_bcd(sel);
        case (sel)
            0:       begin b8  = val[7:0]; s8  = 1'b1; end
            1:       begin bb  = val[7:0]; sb  = 1'b1; end
            2:       begin b16 = val;      s16 = 1'b1; end
            default: begin b1  = val[0:0]; s1  = 1'b1; end
        endcase
        tick();
        s8 = 1'b0; sb = 1'b0; s16 = 1'b0; s1 = 1'b0;
        n    = 0;
        nb   = 0;
        held = 1'b1;
        while (!get_done(sel) && n < 40) begin
            if (get_busy(sel)) nb++;
            if (get_bcd(sel) !== prev) held = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(width_of(sel)));
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(width_of(sel)));
        chk({tag, "_hold"}, 64'(held), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(get_busy(sel)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;

        rst_n = 1'b0;
        s8 = 1'b0; sb = 1'b0; s16 = 1'b0; s1 = 1'b0;
        b8 = '0;   bb = '0;   b16 = '0;   b1 = '0;
        tick();
        tick();

        // Reset state.
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_bcd", 64'(bcd8), 64'h0);
        chk("rst_seg", 64'(seg8), 64'(21'b1000000_1000000_1000000));
        chk("rst_seg_blank", 64'(segb), 64'(21'b1111111_1111111_1000000));
        chk("rst_seg16", 64'(seg16), 64'(35'b0000000_0000000_0000000_0000000_0111111));
        rst_n = 1'b1;
        tick();

        // Maximum 8-bit value.
        run(0, 16'd255, "u8_255");
        chk("u8_255_done", 64'(done8), 64'd1);
        chk("u8_255_bcd", 64'(bcd8), 64'h255);
        chk("u8_255_seg", 64'(seg8), 64'(21'b0100100_0010010_0010010));
        tick();
        chk("u8_255_done_pulse", 64'(done8), 64'd0);
        chk("u8_255_bcd_hold", 64'(bcd8), 64'h255);

        run(0, 16'd99, "u8_99");
        chk("u8_99_bcd", 64'(bcd8), 64'h099);
        run(0, 16'd128, "u8_128");
        chk("u8_128_bcd", 64'(bcd8), 64'h128);

        // Held start: back-to-back conversions, bin_in change mid-SHIFT ignored.
        tick();
        b8 = 8'd123;
        s8 = 1'b1;
        tick();
        tick();
        tick();
        b8 = 8'd9;
        n = 2;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        chk("held_first_latency", 64'(n), 64'd8);
        chk("held_first_bcd", 64'(bcd8), 64'h123);
        tick();
        chk("held_reaccept_busy", 64'(busy8), 64'd1);
        chk("held_reaccept_done", 64'(done8), 64'd0);
        n = 1;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        s8 = 1'b0;
        chk("held_second_latency", 64'(n), 64'd9);
        chk("held_second_bcd", 64'(bcd8), 64'h009);
        tick();

        // Reset during a conversion.
        b8 = 8'd200;
        s8 = 1'b1;
        tick();
        s8 = 1'b0;
        repeat (4) tick();
        chk("midrst_busy_before", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy8), 64'd0);
        chk("midrst_done", 64'(done8), 64'd0);
        chk("midrst_bcd", 64'(bcd8), 64'h0);
        chk("midrst_seg", 64'(seg8), 64'(21'b1000000_1000000_1000000));
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen = 1'b1;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        // Leading-zero blanking, active-low.
        run(1, 16'd0, "blank_0");
        chk("blank_0_bcd", 64'(bcdb), 64'h000);
        chk("blank_0_seg", 64'(segb), 64'(21'b1111111_1111111_1000000));
        run(1, 16'd9, "blank_9");
        chk("blank_9_bcd", 64'(bcdb), 64'h009);
        chk("blank_9_seg", 64'(segb), 64'(21'b1111111_1111111_0010000));
        run(1, 16'd105, "blank_105");
        chk("blank_105_bcd", 64'(bcdb), 64'h105);
        chk("blank_105_seg", 64'(segb), 64'(21'b1111001_1000000_0010010));

        // 16-bit, active-high with blanking.
        run(2, 16'd65535, "u16_65535");
        chk("u16_65535_bcd", 64'(bcd16), 64'h65535);
        chk("u16_65535_seg", 64'(seg16), 64'(35'b1111101_1101101_1101101_1001111_1101101));
        run(2, 16'd10000, "u16_10000");
        chk("u16_10000_bcd", 64'(bcd16), 64'h10000);
        chk("u16_10000_seg", 64'(seg16), 64'(35'b0000110_0111111_0111111_0111111_0111111));
        run(2, 16'd42, "u16_42");
        chk("u16_42_bcd", 64'(bcd16), 64'h00042);
        chk("u16_42_seg", 64'(seg16), 64'(35'b0000000_0000000_0000000_1100110_1011011));

        // Single-bit input.
        run(3, 16'd1, "u1_1");
        chk("u1_1_bcd", 64'(bcd1), 64'h1);
        chk("u1_1_seg", 64'(seg1), 64'(7'b1111001));
        run(3, 16'd0, "u1_0");
        chk("u1_0_bcd", 64'(bcd1), 64'h0);
        chk("u1_0_seg", 64'(seg1), 64'(7'b1000000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Iterative sequential binary-to-BCD converter with integrated 7-segment encoding. It is the parametrised successor to the fixed 8-bit combinational add-3 converter that drives the board displays. It runs the shift-add-3 (double-dabble) algorithm one bit per clock and uses a start/busy/done handshake. It sits between any result register, such as the cipher output byte or a round counter, and the seven-segment digit outputs.

Parameters:
WIDTH, 8, width of the unsigned binary input; legal range 1..32.
DIGITS, 3, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1. Elaboration fails with $error otherwise.
SEG_ACTIVE_LOW, 1, 1 = segment on is driven 0 (board convention); 0 = segment on is driven 1.
BLANK_LEADING, 0, 1 = suppress leading-zero digits on seg_out. Digit 0 is never blanked.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  request a conversion of bin_in; sampled only when the converter is accepting.
bin_in  input  WIDTH  unsigned value; captured in the cycle start is accepted.
busy  output  1  high while a conversion is iterating.
done  output  1  one-cycle pulse; bcd_out/seg_out hold the new result from this cycle onward.
bcd_out  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], and digit 0 is the units digit.
seg_out  output  7*DIGITS  per-digit segments; digit k occupies bits [7k+6:7k], ordered {g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; busy=0, done=0, bcd_out=0, iteration counter=0, scratch cleared.
  - seg_out shows "0" on every digit, or on digit 0 only when BLANK_LEADING=1.
- Reset has priority over every other input, including mid-conversion. An in-flight conversion is discarded and no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: capture bin_in into the shift register, clear the BCD scratch to 0, set count=0, and go to SHIFT.
  - Else stay in IDLE.
- SHIFT (busy=1, done=0), one iteration per cycle:
  - For every scratch digit >= 5, add 3 (4-bit, no carry out).
  - Then shift {scratch, shreg} left by 1. The MSB of shreg enters bit 0 of scratch.
  - count increments. After the iteration with count == WIDTH-1:
    - load bcd_out with the final scratch value;
    - go to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - If start=1: accept a new conversion exactly as in IDLE and go to SHIFT. This gives back-to-back throughput of one result per WIDTH+1 cycles.
  - Else go to IDLE.
- start in SHIFT is ignored: it is not queued, and bin_in changes during SHIFT have no effect.
- Latency:
  - start accepted at edge N → done=1 in the cycle following edge N+WIDTH.
  - bcd_out is valid in the same cycle as done.
- bcd_out and seg_out hold the last completed result until the next done, or until reset. They do not change during SHIFT.
- seg_out is combinational from bcd_out:
  - digits 0..9 use the standard patterns. With active-high polarity (SEG_ACTIVE_LOW=0), 0 = 0111111 ({g..a}); with SEG_ACTIVE_LOW=1 the bits are inverted.
  - codes 10..15 are unreachable; they encode as all segments off.
- Blanking (BLANK_LEADING=1): digit k>0 is blanked (all off) when it and every higher digit equal 0.
- Boundary values:
  - bin_in=0 yields all-zero BCD.
  - bin_in=2^WIDTH-1 must be exact, with no truncation in the top digit.
  - WIDTH=1 completes in 2 cycles.

Test Plan:
- WIDTH=8, DIGITS=3, reset then start with bin_in=8'd255 → busy high 8 cycles, done pulse 9 cycles after the accept edge, bcd_out=12'h255, seg_out digits 2/5/5 active-low {0100100, 0010010, 0010010}.
- bin_in=8'd0 with BLANK_LEADING=1 → bcd_out=12'h000; digit0 seg=1000000; digits 1 and 2 = 1111111 (blank).
- bin_in=8'd123, start held high throughout; bin_in changed to 8'd9 during SHIFT → first done gives 12'h123. The held start is accepted in the DONE cycle, so the next done (9 cycles later) gives 12'h009.
- Conversion of 8'd200 running; rst_n pulled low at iteration 4 → next cycle busy=0, done never pulses, bcd_out=0, state IDLE.
- WIDTH=16, DIGITS=5, bin_in=16'd65535 → bcd_out=20'h65535 after 17 cycles. Repeat with 16'd10000 → 20'h10000.
- WIDTH=8, DIGITS=2 → elaboration error reported (255 needs 3 digits).
